// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester ids.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_AUX = 1'b1
   } port_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and blockram signals of the two-port data-memory arbiter.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic              req0, req1;
   logic              we0, we1;
   logic [AW-1:0]     addr0, addr1;
   logic [DW/8-1:0]   be0, be1;
   logic [DW-1:0]     wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DW-1:0]     rdata0, rdata1;
   logic [AW-1:0]     mem_addr;
   logic [DW/8-1:0]   mem_be;
   logic [DW-1:0]     mem_wdata;
   logic              mem_we;
   logic [DW-1:0]     mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_addr, mem_be, mem_wdata, mem_we
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_addr, mem_be, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_arbiter.sv
// CPU-priority arbiter sharing one blockram between the CPU port and an auxiliary port;
// a starvation counter forces an aux grant after STARVE_LIMIT consecutive CPU wins.
//
// state     | meaning
// ARB_IDLE  | no access in flight, arbitrate
// ARB_ISSUE | latched access driven to memory, gnt pulse
// ARB_RESP  | rvalid/rdata to winner, arbitrate again
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   mem_arbiter_if.slave bus
);

   localparam int BW = DW / 8;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_t      state;
   logic [CW-1:0]   starve_cnt;
   port_id_t        lat_id;
   logic            lat_we;
   logic [AW-1:0]   lat_addr;
   logic [BW-1:0]   lat_be;
   logic [DW-1:0]   lat_wdata;
   logic            gnt0_r, gnt1_r, rvalid0_r, rvalid1_r, mem_we_r;

   logic arb_any, pick_aux;
   assign arb_any  = bus.req0 | bus.req1;
   assign pick_aux = bus.req1 & (~bus.req0 | (starve_cnt == LIMIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
         lat_id     <= PORT_CPU;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_be     <= '0;
         lat_wdata  <= '0;
         gnt0_r     <= 1'b0;
         gnt1_r     <= 1'b0;
         rvalid0_r  <= 1'b0;
         rvalid1_r  <= 1'b0;
         mem_we_r   <= 1'b0;
      end else begin
         gnt0_r    <= 1'b0;
         gnt1_r    <= 1'b0;
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         mem_we_r  <= 1'b0;
         case (state)
            ARB_ISSUE: begin
               rvalid0_r <= (lat_id == PORT_CPU);
               rvalid1_r <= (lat_id == PORT_AUX);
               state     <= ARB_RESP;
            end
            default: begin
               // IDLE and RESP both arbitrate, giving one access per two cycles
               if (arb_any) begin
                  if (pick_aux) begin
                     lat_id     <= PORT_AUX;
                     lat_we     <= bus.we1;
                     lat_addr   <= bus.addr1;
                     lat_be     <= bus.be1;
                     lat_wdata  <= bus.wdata1;
                     gnt1_r     <= 1'b1;
                     mem_we_r   <= bus.we1;
                     starve_cnt <= '0;
                  end else begin
                     lat_id     <= PORT_CPU;
                     lat_we     <= bus.we0;
                     lat_addr   <= bus.addr0;
                     lat_be     <= bus.be0;
                     lat_wdata  <= bus.wdata0;
                     gnt0_r     <= 1'b1;
                     mem_we_r   <= bus.we0;
                     if (!bus.req1)
                        starve_cnt <= '0;
                     else if (starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + CW'(1);
                  end
                  state <= ARB_ISSUE;
               end else begin
                  state <= ARB_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.gnt0      = gnt0_r;
   assign bus.gnt1      = gnt1_r;
   assign bus.rvalid0   = rvalid0_r;
   assign bus.rvalid1   = rvalid1_r;
   assign bus.rdata0    = (rvalid0_r && !lat_we) ? bus.mem_rdata : '0;
   assign bus.rdata1    = (rvalid1_r && !lat_we) ? bus.mem_rdata : '0;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_be    = lat_be;
   assign bus.mem_wdata = lat_wdata;
   assign bus.mem_we    = mem_we_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-enabled blockram model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;

   mem_arbiter_if #(.AW(32), .DW(32)) bus_if ();

   mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:63];

   always @(posedge clk) begin
      if (bus_if.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus_if.mem_be[b]) mem[bus_if.mem_addr[7:2]][8*b +: 8] <= bus_if.mem_wdata[8*b +: 8];
      end
      bus_if.mem_rdata <= mem[bus_if.mem_addr[7:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.req0 = 0; bus_if.we0 = 0; bus_if.addr0 = 0; bus_if.be0 = 0; bus_if.wdata0 = 0;
      bus_if.req1 = 0; bus_if.we1 = 0; bus_if.addr1 = 0; bus_if.be1 = 0; bus_if.wdata1 = 0;
   endtask

   // One port-0 read of addr; checks grant, response and the following idle cycle.
   task automatic cpu_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus_if.req0 = 1; bus_if.we0 = 0; bus_if.addr0 = addr; bus_if.be0 = 4'hf;
      tick();
      chk({tag, "_gnt0"}, 32'(bus_if.gnt0), 32'd1);
      chk({tag, "_addr"}, bus_if.mem_addr, addr);
      chk({tag, "_we"}, 32'(bus_if.mem_we), 32'd0);
      bus_if.req0 = 0;
      tick();
      chk({tag, "_rvalid0"}, 32'(bus_if.rvalid0), 32'd1);
      chk({tag, "_rdata0"}, bus_if.rdata0, exp);
      tick();
      chk({tag, "_after"}, {29'd0, bus_if.rvalid0, bus_if.gnt0, |bus_if.rdata0}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;
      mem[8] = 32'h11223344;
      idle_inputs();

      // reset state
      #12;
      chk("rst_out", {25'd0, bus_if.gnt0, bus_if.gnt1, bus_if.rvalid0, bus_if.rvalid1,
                      bus_if.mem_we, |bus_if.rdata0, |bus_if.rdata1}, 32'd0);
      chk("rst_addr", bus_if.mem_addr, 32'd0);
      chk("rst_wdata", bus_if.mem_wdata, 32'd0);
      chk("rst_be", 32'(bus_if.mem_be), 32'd0);
      chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
      @(negedge clk);
      reset = 0;
      tick();

      // single CPU read
      cpu_read("rd10", 32'h10, 32'hDEADBEEF);

      // byte write on port 1
      bus_if.req1 = 1; bus_if.we1 = 1; bus_if.addr1 = 32'h20; bus_if.be1 = 4'b0010;
      bus_if.wdata1 = 32'h0000AB00;
      tick();
      chk("bw_gnt1", 32'(bus_if.gnt1), 32'd1);
      chk("bw_gnt0", 32'(bus_if.gnt0), 32'd0);
      chk("bw_we", 32'(bus_if.mem_we), 32'd1);
      chk("bw_be", 32'(bus_if.mem_be), 32'h2);
      chk("bw_addr", bus_if.mem_addr, 32'h20);
      chk("bw_wdata", bus_if.mem_wdata, 32'h0000AB00);
      bus_if.req1 = 0;
      tick();
      chk("bw_we_drop", 32'(bus_if.mem_we), 32'd0);
      chk("bw_rvalid1", 32'(bus_if.rvalid1), 32'd1);
      chk("bw_rdata1", bus_if.rdata1, 32'd0);
      tick();
      cpu_read("rb20", 32'h20, 32'h1122AB44);

      // contention, limit 4: expected grants 0,0,0,0,1,0,0,0,0,1
      bus_if.req0 = 1; bus_if.we0 = 0; bus_if.addr0 = 32'h10; bus_if.be0 = 4'hf;
      bus_if.req1 = 1; bus_if.we1 = 0; bus_if.addr1 = 32'h20; bus_if.be1 = 4'hf;
      tick();
      for (int k = 0; k < 10; k++) begin
         logic exp_aux;
         exp_aux = ((k % 5) == 4);
         chk($sformatf("ct_gnt_%0d", k), {30'd0, bus_if.gnt1, bus_if.gnt0},
             exp_aux ? 32'd2 : 32'd1);
         if (k == 9) begin
            bus_if.req0 = 0; bus_if.req1 = 0;
         end
         tick();
         chk($sformatf("ct_rsp_%0d", k), {28'd0, bus_if.gnt1, bus_if.gnt0, bus_if.rvalid1, bus_if.rvalid0},
             exp_aux ? 32'd2 : 32'd1);
         if (exp_aux) chk($sformatf("ct_rdata1_%0d", k), bus_if.rdata1, 32'h1122AB44);
         else         chk($sformatf("ct_rdata0_%0d", k), bus_if.rdata0, 32'hDEADBEEF);
         tick();
      end
      chk("ct_done", {30'd0, bus_if.gnt1, bus_if.gnt0}, 32'd0);
      tick();

      // req1 withdrawn before arbitration: only CPU grants, counter stays 0
      bus_if.req0 = 1; bus_if.req1 = 1;
      #2;
      bus_if.req1 = 0;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wd_gnt_%0d", k), {30'd0, bus_if.gnt1, bus_if.gnt0}, 32'd1);
         chk($sformatf("wd_cnt_%0d", k), 32'(dut.starve_cnt), 32'd0);
         if (k == 2) bus_if.req0 = 0;
         tick();
         tick();
      end

      // reset during ISSUE of a write
      bus_if.req0 = 1; bus_if.we0 = 1; bus_if.addr0 = 32'h10; bus_if.be0 = 4'hf;
      bus_if.wdata0 = 32'hCAFEF00D;
      tick();
      chk("rw_we_on", 32'(bus_if.mem_we), 32'd1);
      bus_if.req0 = 0; bus_if.we0 = 0;
      #1;
      reset = 1;
      #1;
      chk("rw_we_off", 32'(bus_if.mem_we), 32'd0);
      chk("rw_gnt_off", 32'(bus_if.gnt0), 32'd0);
      tick();
      chk("rw_no_rvalid", {30'd0, bus_if.rvalid1, bus_if.rvalid0}, 32'd0);
      chk("rw_mem", mem[4], 32'hDEADBEEF);
      reset = 0;
      tick();
      chk("rw_state", 32'(dut.state), 32'(ARB_IDLE));
      cpu_read("rw_rb", 32'h10, 32'hDEADBEEF);

      // idle bus
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("idle_%0d", k), {25'd0, bus_if.gnt0, bus_if.gnt1, bus_if.rvalid0, bus_if.rvalid1,
                                        bus_if.mem_we, |bus_if.rdata0, |bus_if.rdata1}, 32'd0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single data-memory blockram between the CPU load/store port (port 0) and an auxiliary requester (port 1, e.g. debug loader or video fetch). The CPU has priority. A starvation counter guarantees that port 1 is served within a bounded number of CPU accesses. It sits between the requesters and the blockram and drives the blockram's address, byte-enable, write-data and write-enable inputs. The blockram returns read data one clock after the access is issued.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; `DW/8` byte enables.
- `STARVE_LIMIT`, default 4: maximum consecutive port-0 grants while port 1 waits; must be ≥1.

Ports:
- `clk` in 1: single clock; all state is updated on `posedge clk`.
- `reset` in 1: asynchronous, active-high.
- `req0` / `req1` in 1: access request, held until the grant pulse.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in AW: byte address.
- `be0` / `be1` in DW/8: byte enables.
- `wdata0` / `wdata1` in DW: write data.
- `gnt0` / `gnt1` out 1: one-cycle pulse in the cycle the access is issued to memory.
- `rvalid0` / `rvalid1` out 1: one-cycle completion pulse. It pulses for writes too.
- `rdata0` / `rdata1` out DW: read data. Valid only while the matching `rvalid` is high; 0 otherwise.
- `mem_addr` out AW, `mem_be` out DW/8, `mem_wdata` out DW, `mem_we` out 1: blockram side.
- `mem_rdata` in DW: blockram read data, one cycle after issue.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: drive memory.
  - RESP: return data, and arbitrate again.
- Arbitration runs in IDLE and RESP. With no request pending, the next state is IDLE. Otherwise the winner's `we`/`addr`/`be`/`wdata` are latched into internal registers, along with a winner-id bit, and the next state is ISSUE.
- Winner rule:
  - Only one request pending: that port wins.
  - Both pending: port 0 wins unless `starve_cnt == STARVE_LIMIT`, in which case port 1 wins.
- `starve_cnt` update, evaluated only at an arbitration that grants something:
  - Port 0 wins while `req1` is high: increment.
  - Port 1 wins, or `req1` is low: clear to 0.
  - It saturates at `STARVE_LIMIT`; its width is `$clog2(STARVE_LIMIT+1)`.
- ISSUE:
  - `mem_*` are driven from the latched registers.
  - `mem_we` equals the latched `we` in this state only.
  - `gnt<winner>` = 1.
  - Next state is RESP.
- RESP:
  - `rvalid<winner>` = 1 and `rdata<winner>` = `mem_rdata` (combinational pass-through); for writes, `rdata` is don't-care-as-0.
  - `mem_we` = 0.
  - Arbitration runs in the same cycle, so back-to-back accesses reach 1 access per 2 cycles.
- Request stability:
  - Request fields are sampled only at arbitration.
  - A request withdrawn after its arbitration cycle still completes.
  - A requester must not re-assert for a new access until it has seen its `rvalid`.
- Outside ISSUE, `mem_addr`/`mem_be`/`mem_wdata` hold their last latched values, and `mem_we` is 0.

## Timing
- Request seen in IDLE at cycle N: `gnt` at N+1, `rvalid`/`rdata` at N+2.
- Next arbitration happens at N+2, so the next grant comes at N+3 at the earliest.
- Reset values:
  - state IDLE, `starve_cnt` 0, latched registers 0.
  - All `gnt`/`rvalid`/`rdata`/`mem_*` outputs are 0.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). A write that was in ISSUE drops `mem_we` at once. The in-flight access is discarded and gets no `rvalid`.
- Simultaneous `req0` and `req1` with `STARVE_LIMIT` reached: port 1 is granted, `starve_cnt` goes to 0, and port 0 is served at the next arbitration.

## Structure
- A shared package holds the state enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_RESP`) and the port-id encoding (`PORT_CPU` = 0, `PORT_AUX` = 1).
- A single module; the starvation counter stays inline. No sub-module.

## Test plan
- Single CPU read: `req0`, `addr0` = 0x10, memory holds 0xDEADBEEF → `gnt0` at N+1 with `mem_addr` = 0x10 and `mem_we` = 0; `rvalid0` at N+2 with `rdata0` = 0xDEADBEEF.
- Byte write on port 1: `addr1` = 0x20, `be1` = 4'b0010, `wdata1` = 0x0000AB00 → `mem_we` = 1 for exactly one cycle, `mem_be` = 4'b0010, `rvalid1` one cycle later; a read-back of 0x20 returns only byte 1 changed.
- Contention with `STARVE_LIMIT` = 4 and both requests held continuously → grant sequence 0,0,0,0,1,0,0,0,0,1,… with one grant every 2 cycles.
- Simultaneous requests with `req1` dropped before any arbitration → only port-0 grants occur, and `starve_cnt` stays 0.
- Reset asserted during ISSUE of a write → `mem_we` falls in the same cycle, no `rvalid`, memory is unchanged, and the FSM restarts in IDLE.
- Idle bus → all outputs stay 0 and `mem_we` is never asserted.
